// File: rtl/rotl_engine.sv
// rotl_engine: multi-cycle variable-amount rotator.
// Takes a word and amount over valid/ready, rotates at most STEP bits per
// clock, then presents the result over a second valid/ready handshake.
// Optional macro ROTL_ENGINE_BIDIR_EN adds an in_dir port (1 = rotate right).
module rotl_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
`ifdef ROTL_ENGINE_BIDIR_EN
  input  logic             in_dir,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
  localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] rot_next;
  logic [AW-1:0]    rem;
  logic [AW-1:0]    s;
  logic [AW:0]      sh_back;
  logic             last;
`ifdef ROTL_ENGINE_BIDIR_EN
  logic             dir;
`endif

  // Per-cycle step size, complementary shift and rotated candidate word
  always_comb begin
    s        = ({1'b0, rem} < STEP_W) ? rem : STEP_W[AW-1:0];
    sh_back  = WIDTH_W - {1'b0, s};
    last     = (rem == s);
    rot_next = (work << s) | (work >> sh_back);
`ifdef ROTL_ENGINE_BIDIR_EN
    if (dir) begin
      rot_next = (work >> s) | (work << sh_back);
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_amt == '0) ? HOLD : ROT;
        end
      end
      ROT: begin
        if (last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      ROT:     busy      = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: capture request, step the rotation, publish the final word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work     <= '0;
      rem      <= '0;
      out_data <= '0;
`ifdef ROTL_ENGINE_BIDIR_EN
      dir      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            rem  <= in_amt;
`ifdef ROTL_ENGINE_BIDIR_EN
            dir  <= in_dir;
`endif
            if (in_amt == '0) begin
              out_data <= in_data;
            end
          end
        end
        ROT: begin
          work <= rot_next;
          rem  <= rem - s;
          if (last) begin
            out_data <= rot_next;
          end
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

endmodule

// File: doc/rotl_engine.md
Name: rotl_engine

Overview:
- Multi-cycle rotate-left unit: the inverse-direction counterpart of the fixed right-rotators in the SHA-256 datapath.
- Accepts a word and a variable rotate amount over a valid/ready handshake.
- Rotates by at most STEP bits per clock, then presents the result over a second valid/ready handshake.
- Used to undo rotr stages in the message-schedule self-check path and to share one rotator across variable-amount requests.

Parameters:
- WIDTH, 32, data word width in bits; power of two, at least 8.
- STEP, 4, maximum bits rotated per ROT cycle; power of two, 1..WIDTH.
- AW, $clog2(WIDTH), rotate-amount width (derived; do not override).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset: synchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- in_data  input  WIDTH  word to rotate.
- in_amt  input  AW  rotate amount, 0..WIDTH-1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  rotated word.
- busy  output  1  high in ROT or HOLD.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE; in_ready=1, out_valid=0, out_data=0, busy=0.
  - The remaining-amount counter and internal data register clear.
  - Reset overrides everything, including mid-ROT and mid-HOLD; an in-flight request is dropped with no output.
- FSM states: IDLE, ROT, HOLD.
- IDLE:
  - in_ready=1.
  - Accept on posedge with in_valid&in_ready: latch in_data into work register and in_amt into rem.
  - If in_amt==0, go directly to HOLD. Otherwise go to ROT.
- ROT:
  - in_ready=0.
  - Each posedge: work <= rotl(work, s) where s=min(rem,STEP); rem <= rem-s.
  - When rem-s==0, go to HOLD.
  - ROT lasts exactly N=ceil(amt/STEP) cycles.
- HOLD:
  - out_valid=1; out_data=work, held stable while out_ready=0 (no change on any bit).
  - On posedge with out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept at edge k; out_valid is high in the cycle after edge k+N.
  - amt=0 gives out_valid the cycle after accept.
- No overlap: a new request is accepted only in IDLE. Throughput is one request per N+2 cycles minimum with out_ready tied high.
- in_valid while not in IDLE is ignored; the request must be held by the source until in_ready.
- Rotation semantics: rotl(x,s) = (x<<s)|(x>>(WIDTH-s)) within WIDTH bits; s=0 is identity.
  - Full rotate result must equal single-step rotl(in_data,in_amt).
- The amount is taken modulo WIDTH by construction of AW; no out-of-range values exist.
- out_data retains the last result after the HOLD→IDLE transition until the next HOLD; it is only valid while out_valid=1.
- busy = (state!=IDLE).

Optional Feature:
- Macro ROTL_ENGINE_BIDIR_EN.
- Defined:
  - Adds input port in_dir (1 bit, after in_amt), latched at accept.
  - in_dir=0 rotates left as above; in_dir=1 rotates right by the same stepping rules, with identical latency, handshake and reset behaviour.
- Undefined:
  - in_dir port is absent; left rotation only.

Test Plan:
- Reset then in_data=0x80000001, in_amt=1, STEP=4 → 1 ROT cycle; out_valid the cycle after edge k+1; out_data=0x00000003.
- in_data=0x12345678, in_amt=0 → out_valid the cycle after accept; out_data=0x12345678; in_ready=0 until handshake.
- in_data=0x12345678, in_amt=31, STEP=4 → 8 ROT cycles; out_data=0x091A2B3C; busy high throughout.
- Backpressure: in_amt=8, data 0xDEADBEEF, out_ready low 5 cycles → out_data=0xADBEEFDE held stable, out_valid high; in_valid pulses during HOLD ignored; IDLE one cycle after out_ready.
- rst_n low for one edge during ROT of in_amt=20 → next cycle IDLE, out_valid=0, out_data=0, in_ready=1; no result emitted. A following request of 0xA5A5A5A5, in_amt=4 returns 0x5A5A5A5A.
- ROTL_ENGINE_BIDIR_EN defined: in_data=0x00000001, in_amt=1, in_dir=1 → out_data=0x80000000. Random 1000 requests in both directions match the reference model.
